fragment_writer: RTL

Fragment sink for the rasterizer output stream. It accepts fragments (x, y, depth, R, G, B) over ready/valid, converts them to screen coordinates, performs a depth test against an external depth buffer, and writes surviving pixels as RGB565 to an external framebuffer write port. It also runs a full-screen clear of both buffers on request, and sits directly downstream of the rasterizer core's fragment output.

---
 rtl/fragment_writer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fragment_writer.sv
// Fragment sink: screen-space cull, optional depth test, RGB565 framebuffer write, full-screen clear.
// Define FRAGMENT_WRITER_DEPTH_TEST_EN to enable the external depth-buffer read/compare/write path.
module fragment_writer #(
  parameter int          INT_BITS      = 16,
  parameter int          FRAC_BITS     = 16,
  parameter int          DATA_WIDTH    = INT_BITS + FRAC_BITS,
  parameter int          N_ATTR        = 4,
  parameter int          SCREEN_WIDTH  = 640,
  parameter int          SCREEN_HEIGHT = 360,
  parameter int          ADDR_WIDTH    = 18,
  parameter logic [15:0] CLEAR_COLOR   = 16'h0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] i_fragment_x,
  input  logic signed [DATA_WIDTH-1:0] i_fragment_y,
  input  logic signed [DATA_WIDTH-1:0] i_fragment_attr [N_ATTR],
  input  logic                         i_dv,
  output logic                         o_ready,
  input  logic                         i_clear,
  output logic                         o_zbuf_rd_en,
  output logic [ADDR_WIDTH-1:0]        o_zbuf_rd_addr,
  input  logic [15:0]                  i_zbuf_rd_data,
  output logic                         o_zbuf_wr_en,
  output logic [ADDR_WIDTH-1:0]        o_zbuf_wr_addr,
  output logic [15:0]                  o_zbuf_wr_data,
  output logic                         o_fb_wr_en,
  output logic [ADDR_WIDTH-1:0]        o_fb_wr_addr,
  output logic [15:0]                  o_fb_wr_data,
  input  logic                         i_fb_ready,
  output logic                         o_busy,
  output logic [31:0]                  o_written_count,
  output logic [31:0]                  o_rejected_count
);
  localparam int N_PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_PIXELS - 1);

  typedef enum logic [2:0] {IDLE, READ, COMPARE, WRITE, CLEAR} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, r_clr_cnt;
  logic [15:0]           r_rgb;
  logic                  r_clear_pending;
  logic [31:0]           r_written_count, r_rejected_count;
  logic                  w_inc_wr, w_inc_rej, w_clr_done, w_accept, w_offscreen;
  logic [INT_BITS-1:0]   w_px, w_py;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [15:0]           w_r16, w_g16, w_b16, w_rgb;

  // Negative -> 0, >= 1.0 -> all ones, else the top 16 fraction bits.
  function automatic logic [15:0] f_clamp16(input logic signed [DATA_WIDTH-1:0] a);
    if (a[DATA_WIDTH-1])                  return 16'h0000;
    else if (a[DATA_WIDTH-2:FRAC_BITS] != '0) return 16'hFFFF;
    else                                  return a[FRAC_BITS-1 -: 16];
  endfunction

  assign w_px        = i_fragment_x[DATA_WIDTH-1:FRAC_BITS];
  assign w_py        = i_fragment_y[DATA_WIDTH-1:FRAC_BITS];
  assign w_offscreen = w_px[INT_BITS-1] | (w_px >= INT_BITS'(SCREEN_WIDTH)) |
                       w_py[INT_BITS-1] | (w_py >= INT_BITS'(SCREEN_HEIGHT));
  assign w_addr      = ADDR_WIDTH'(w_py) * ADDR_WIDTH'(SCREEN_WIDTH) + ADDR_WIDTH'(w_px);
  assign w_r16       = f_clamp16(i_fragment_attr[1]);
  assign w_g16       = f_clamp16(i_fragment_attr[2]);
  assign w_b16       = f_clamp16(i_fragment_attr[3]);
  assign w_rgb       = {w_r16[15:11], w_g16[15:10], w_b16[15:11]};
  assign w_accept    = (r_state == IDLE) && !r_clear_pending && i_dv;

`ifdef FRAGMENT_WRITER_DEPTH_TEST_EN
  logic [15:0] r_z16;
  logic        w_unused_bits;
  assign w_unused_bits = ^{i_fragment_x[FRAC_BITS-1:0], i_fragment_y[FRAC_BITS-1:0],
                           w_r16[10:0], w_g16[9:0], w_b16[10:0]};

  always_ff @(posedge clk) begin
    if (rst)                          r_z16 <= '0;
    else if (w_accept && !w_offscreen) r_z16 <= f_clamp16(i_fragment_attr[0]);
  end
`else
  logic w_unused_bits;
  assign w_unused_bits = ^{i_fragment_x[FRAC_BITS-1:0], i_fragment_y[FRAC_BITS-1:0],
                           w_r16[10:0], w_g16[9:0], w_b16[10:0],
                           i_fragment_attr[0], i_zbuf_rd_data};
`endif

  always_comb begin
    w_state_nxt    = r_state;
    o_ready        = 1'b0;
    o_busy         = 1'b1;
    o_zbuf_rd_en   = 1'b0;
    o_zbuf_rd_addr = '0;
    o_zbuf_wr_en   = 1'b0;
    o_zbuf_wr_addr = '0;
    o_zbuf_wr_data = '0;
    o_fb_wr_en     = 1'b0;
    o_fb_wr_addr   = '0;
    o_fb_wr_data   = '0;
    w_inc_wr       = 1'b0;
    w_inc_rej      = 1'b0;
    w_clr_done     = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        // A pending clear takes priority over accepting the next fragment.
        if (r_clear_pending) begin
          w_state_nxt = CLEAR;
        end else begin
          o_ready = 1'b1;
          if (i_dv) begin
            if (w_offscreen) w_inc_rej = 1'b1;
`ifdef FRAGMENT_WRITER_DEPTH_TEST_EN
            else             w_state_nxt = READ;
`else
            else             w_state_nxt = WRITE;
`endif
          end
        end
      end
`ifdef FRAGMENT_WRITER_DEPTH_TEST_EN
      READ: begin
        o_zbuf_rd_en   = 1'b1;
        o_zbuf_rd_addr = r_addr;
        w_state_nxt    = COMPARE;
      end
      COMPARE: begin
        if (r_z16 < i_zbuf_rd_data) begin
          w_state_nxt = WRITE;
        end else begin
          w_inc_rej   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
`endif
      WRITE: begin
        o_fb_wr_en   = 1'b1;
        o_fb_wr_addr = r_addr;
        o_fb_wr_data = r_rgb;
`ifdef FRAGMENT_WRITER_DEPTH_TEST_EN
        o_zbuf_wr_en   = i_fb_ready;
        o_zbuf_wr_addr = r_addr;
        o_zbuf_wr_data = r_z16;
`endif
        if (i_fb_ready) begin
          w_inc_wr    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      CLEAR: begin
        o_fb_wr_en   = 1'b1;
        o_fb_wr_addr = r_clr_cnt;
        o_fb_wr_data = CLEAR_COLOR;
`ifdef FRAGMENT_WRITER_DEPTH_TEST_EN
        o_zbuf_wr_en   = i_fb_ready;
        o_zbuf_wr_addr = r_clr_cnt;
        o_zbuf_wr_data = 16'hFFFF;
`endif
        if (i_fb_ready && (r_clr_cnt == LAST_ADDR)) begin
          w_clr_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_addr           <= '0;
      r_rgb            <= '0;
      r_clear_pending  <= 1'b0;
      r_clr_cnt        <= '0;
      r_written_count  <= '0;
      r_rejected_count <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_clear_pending <= i_clear | (r_clear_pending & ~w_clr_done);
      if (w_accept && !w_offscreen) begin
        r_addr <= w_addr;
        r_rgb  <= w_rgb;
      end
      if (r_state == IDLE)                    r_clr_cnt <= '0;
      else if (r_state == CLEAR && i_fb_ready) r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
      if (w_inc_wr)  r_written_count  <= r_written_count + 32'd1;
      if (w_inc_rej) r_rejected_count <= r_rejected_count + 32'd1;
    end
  end

  assign o_written_count  = r_written_count;
  assign o_rejected_count = r_rejected_count;
endmodule
